// File: rtl/stop_watch_ctrl.sv
`timescale 1ns/1ps
// stop_watch_ctrl: conditions the stopwatch front-panel buttons and sequences the BCD counter.
// Define STOP_WATCH_AUTOSTOP_EN to halt a down-count at 00:00 (DONE) instead of letting it wrap.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | stopped, prescaler cleared; dir may be toggled
//   RUN   | prescaler counting, tick every TICK_DIV cycles
//   PAUSE | stopped, prescaler holds the partial period; dir may be toggled
//   DONE  | down-count reached zero; only clear or set leave

module stop_watch_ctrl #(
   parameter int TICK_DIV  = 100000,
   parameter int DB_CYCLES = 16,
   parameter int CW        = 17
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_start,
   input  logic       btn_clear,
   input  logic       btn_set,
   input  logic       btn_dir,
   input  logic       cnt_zero,
   output logic       cnt_clr,
   output logic       cnt_load,
   output logic       cnt_up,
   output logic       tick,
   output logic       running,
   output logic [1:0] state
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_RUN   = 2'b01,
      S_PAUSE = 2'b10,
      S_DONE  = 2'b11
   } state_t;

   localparam int            NB         = 4;
   localparam logic [CW-1:0] PRESC_LAST = CW'(TICK_DIV - 1);
   localparam logic [CW-1:0] DB_LAST    = CW'(DB_CYCLES - 1);

   // button index: 0 start, 1 clear, 2 set, 3 dir
   logic [NB-1:0] btn_raw;
   logic [NB-1:0] sync_1;
   logic [NB-1:0] sync_2;
   logic [NB-1:0] db_lvl;
   logic [NB-1:0] db_lvl_d;
   logic [NB-1:0] cmd;
   logic [CW-1:0] db_cnt [NB];

   assign btn_raw = {btn_dir, btn_set, btn_clear, btn_start};

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_1   <= '0;
         sync_2   <= '0;
         db_lvl   <= '0;
         db_lvl_d <= '0;
         for (int i = 0; i < NB; i++) begin
            db_cnt[i] <= '0;
         end
      end else begin
         sync_1   <= btn_raw;
         sync_2   <= sync_1;
         db_lvl_d <= db_lvl;
         for (int i = 0; i < NB; i++) begin
            if (sync_2[i] != db_lvl[i]) begin
               if (db_cnt[i] == DB_LAST) begin
                  db_lvl[i] <= sync_2[i];
                  db_cnt[i] <= '0;
               end else begin
                  db_cnt[i] <= db_cnt[i] + 1'b1;
               end
            end else begin
               db_cnt[i] <= '0;
            end
         end
      end
   end

   assign cmd = db_lvl & ~db_lvl_d;

   state_t        st_q;
   state_t        st_base;
   state_t        st_nxt;
   logic [CW-1:0] presc_q;
   logic [CW-1:0] presc_nxt;
   logic          up_nxt;
   logic          clr_nxt;
   logic          load_nxt;
   logic          tick_raw;
   logic          tick_nxt;
   logic          autostop;

   always_comb begin
      st_base   = st_q;
      presc_nxt = presc_q;
      up_nxt    = cnt_up;
      clr_nxt   = 1'b0;
      load_nxt  = 1'b0;
      if (st_q == S_RUN) begin
         presc_nxt = (presc_q == PRESC_LAST) ? '0 : presc_q + 1'b1;
      end
      if (cmd[1]) begin
         clr_nxt   = 1'b1;
         st_base   = S_IDLE;
         presc_nxt = '0;
      end else if (cmd[2]) begin
         load_nxt  = 1'b1;
         up_nxt    = 1'b0;
         st_base   = S_IDLE;
         presc_nxt = '0;
      end else if (cmd[0]) begin
         case (st_q)
            S_IDLE: begin
               st_base   = S_RUN;
               presc_nxt = '0;
            end
            S_RUN:   st_base = S_PAUSE;
            S_PAUSE: st_base = S_RUN;
            default: ;
         endcase
      end else if (cmd[3] && (st_q == S_IDLE || st_q == S_PAUSE)) begin
         up_nxt = ~cnt_up;
      end
   end

   // tick is registered, so the decision is taken one edge early on the next prescaler value
   assign tick_raw = (st_base == S_RUN) && (presc_nxt == PRESC_LAST);

`ifdef STOP_WATCH_AUTOSTOP_EN
   // cnt_zero only moves on a counter edge, so its value now equals its value in the tick cycle
   assign autostop = tick_raw && !up_nxt && cnt_zero;
`else
   logic unused_cnt_zero;
   assign unused_cnt_zero = cnt_zero;
   assign autostop        = 1'b0;
`endif

   assign st_nxt   = autostop ? S_DONE : st_base;
   assign tick_nxt = tick_raw && !autostop;

   always_ff @(posedge clk) begin
      if (reset) begin
         st_q     <= S_IDLE;
         presc_q  <= '0;
         cnt_up   <= 1'b1;
         cnt_clr  <= 1'b1;
         cnt_load <= 1'b0;
         tick     <= 1'b0;
         running  <= 1'b0;
      end else begin
         st_q     <= st_nxt;
         presc_q  <= presc_nxt;
         cnt_up   <= up_nxt;
         cnt_clr  <= clr_nxt;
         cnt_load <= load_nxt;
         tick     <= tick_nxt;
         running  <= (st_nxt == S_RUN);
      end
   end

   assign state = st_q;

endmodule

// File: tb/tb_stop_watch_ctrl.sv
`timescale 1ns/1ps
// Bench for stop_watch_ctrl: directed scenarios plus randomized button traffic, checked every
// cycle against a behavioural model built from debounce windows and counted RUN cycles.

module tb_stop_watch_ctrl;

   localparam int TD = 4;
   localparam int DB = 2;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] btn;          // 0 start, 1 clear, 2 set, 3 dir
   logic       cnt_zero;
   logic       cnt_clr, cnt_load, cnt_up, tick, running;
   logic [1:0] state;

   int n_chk = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   stop_watch_ctrl #(.TICK_DIV(TD), .DB_CYCLES(DB), .CW(17)) dut (
      .clk      (clk),
      .reset    (reset),
      .btn_start(btn[0]),
      .btn_clear(btn[1]),
      .btn_set  (btn[2]),
      .btn_dir  (btn[3]),
      .cnt_zero (cnt_zero),
      .cnt_clr  (cnt_clr),
      .cnt_load (cnt_load),
      .cnt_up   (cnt_up),
      .tick     (tick),
      .running  (running),
      .state    (state)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   bit [3:0]    m_s1, m_s2, m_deb, m_deb_d;
   bit [DB-1:0] m_win [4];
   int          m_state;     // 0 idle, 1 run, 2 pause, 3 done
   int          m_rc;        // RUN cycles completed since IDLE->RUN, modulo TD
   bit          m_up, m_clr, m_load;
   logic [6:0]  exp_outs;

   task automatic model_edge();
      bit [3:0] cmd;
      if (reset) begin
         m_s1 = '0; m_s2 = '0; m_deb = '0; m_deb_d = '0;
         for (int i = 0; i < 4; i++) m_win[i] = '0;
         m_state = 0; m_rc = 0; m_up = 1'b1; m_clr = 1'b1; m_load = 1'b0;
      end else begin
         cmd = m_deb & ~m_deb_d;
         m_clr = 1'b0;
         m_load = 1'b0;
         if (m_state == 1) m_rc = (m_rc + 1) % TD;
         if (cmd[1]) begin
            m_clr = 1'b1; m_state = 0; m_rc = 0;
         end else if (cmd[2]) begin
            m_load = 1'b1; m_up = 1'b0; m_state = 0; m_rc = 0;
         end else if (cmd[0]) begin
            if (m_state == 0) begin
               m_state = 1; m_rc = 0;
            end else if (m_state == 1) m_state = 2;
            else if (m_state == 2) m_state = 1;
         end else if (cmd[3] && (m_state == 0 || m_state == 2)) begin
            m_up = !m_up;
         end
`ifdef STOP_WATCH_AUTOSTOP_EN
         if (m_state == 1 && m_rc == TD - 1 && !m_up && cnt_zero) m_state = 3;
`endif
         m_deb_d = m_deb;
         // a level is accepted once the last DB synchronised samples all disagree with it
         for (int i = 0; i < 4; i++) begin
            m_win[i] = (m_win[i] << 1) | DB'(m_s2[i]);
            if (m_win[i] == {DB{~m_deb[i]}}) m_deb[i] = ~m_deb[i];
         end
         m_s2 = m_s1;
         m_s1 = btn;
      end
      exp_outs = {2'(m_state), m_state == 1, (m_state == 1) && (m_rc == TD - 1),
                  m_clr, m_load, m_up};
   endtask

   always @(posedge clk) model_edge();

   always @(negedge clk) begin
      if (chk_en) check("outs", 32'({state, running, tick, cnt_clr, cnt_load, cnt_up}),
                        32'(exp_outs));
   end

   // ---------------- stimulus helpers ----------------
   task automatic tap(input int idx);
      btn[idx] = 1'b1;
      repeat (DB + 3) @(negedge clk);
      btn[idx] = 1'b0;
      repeat (DB + 4) @(negedge clk);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt, cnt2, prev;
      reset = 1'b1;
      btn = '0;
      cnt_zero = 1'b0;
      @(negedge clk);
      chk_en = 1'b1;
      repeat (2) @(negedge clk);

      // reset release
      reset = 1'b0;
      check("rst_clr_hi", 32'(cnt_clr), 32'd1);
      check("rst_state", 32'(state), 32'd0);
      check("rst_up", 32'(cnt_up), 32'd1);
      @(negedge clk);
      check("rst_clr_lo", 32'(cnt_clr), 32'd0);
      cnt = 0;
      repeat (50) begin
         @(negedge clk);
         cnt += int'(tick);
      end
      check("rst_no_tick", 32'(cnt), 32'd0);

      // clean start: RUN visible after edge DB+3, ticks on RUN cycles 4, 8
      btn[0] = 1'b1;
      repeat (DB + 2) @(negedge clk);
      check("start_lat_pre", 32'(state), 32'd0);
      @(negedge clk);
      check("start_lat", 32'(state), 32'd1);
      btn[0] = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         check("tick_period", 32'(tick), 32'(k % TD == 0));
         @(negedge clk);
      end
      repeat (2) @(negedge clk);
      tap(0);
      check("pause_state", 32'(state), 32'd2);
      cnt = 0;
      repeat (20) begin
         @(negedge clk);
         cnt += int'(tick);
      end
      check("pause_no_tick", 32'(cnt), 32'd0);
      tap(0);
      check("resume_state", 32'(state), 32'd1);
      repeat (10) @(negedge clk);

      // bounce then long hold from IDLE
      tap(1);
      btn[0] = 1'b1;
      @(negedge clk);
      btn[0] = 1'b0;
      @(negedge clk);
      btn[0] = 1'b1;
      cnt = 0; cnt2 = 0; prev = int'(state);
      repeat (100) begin
         @(negedge clk);
         if (prev == 0 && state == 2'd1) cnt++;
         if (int'(state) != prev) cnt2++;
         prev = int'(state);
      end
      check("bounce_runs", 32'(cnt), 32'd1);
      check("bounce_changes", 32'(cnt2), 32'd1);
      btn[0] = 1'b0;
      repeat (DB + 4) @(negedge clk);

      // clear and start together while running
      btn[0] = 1'b1;
      btn[1] = 1'b1;
      cnt = 0; cnt2 = 0;
      repeat (DB + 10) begin
         @(negedge clk);
         cnt += int'(cnt_clr);
         if (state == 2'd2) cnt2++;
      end
      check("clr_pulses", 32'(cnt), 32'd1);
      check("clr_no_pause", 32'(cnt2), 32'd0);
      check("clr_state", 32'(state), 32'd0);
      btn = '0;
      repeat (DB + 4) @(negedge clk);

      // direction in PAUSE and RUN, then preset
      tap(0);
      tap(0);
      tap(3);
      check("dir_pause", 32'(cnt_up), 32'd0);
      tap(0);
      tap(3);
      check("dir_run", 32'(cnt_up), 32'd0);
      check("dir_run_state", 32'(state), 32'd1);
      btn[2] = 1'b1;
      cnt = 0;
      repeat (DB + 8) begin
         @(negedge clk);
         cnt += int'(cnt_load);
      end
      btn[2] = 1'b0;
      check("set_pulses", 32'(cnt), 32'd1);
      check("set_up", 32'(cnt_up), 32'd0);
      check("set_state", 32'(state), 32'd0);
      repeat (DB + 4) @(negedge clk);

      // counting down at zero
      cnt_zero = 1'b1;
      btn[0] = 1'b1;
      repeat (DB + 3) @(negedge clk);
      check("zero_run", 32'(state), 32'd1);
      cnt = 0;
      for (int k = 1; k <= 12; k++) begin
         if (k > 1) @(negedge clk);
         cnt += int'(tick);
      end
      btn[0] = 1'b0;
      repeat (DB + 4) @(negedge clk);
`ifdef STOP_WATCH_AUTOSTOP_EN
      check("zero_ticks", 32'(cnt), 32'd0);
      check("zero_done", 32'(state), 32'd3);
      tap(0);
      check("done_start_ignored", 32'(state), 32'd3);
      tap(3);
      check("done_dir_ignored", 32'(cnt_up), 32'd0);
`else
      check("zero_ticks", 32'(cnt), 32'd3);
      check("zero_run_kept", 32'(state), 32'd1);
      tap(0);
      check("zero_pause", 32'(state), 32'd2);
`endif
      tap(1);
      check("zero_clear", 32'(state), 32'd0);
      cnt_zero = 1'b0;

      // randomized button traffic
      for (int it = 0; it < 80; it++) begin
         int  r, hold, gap;
         bit  bnc;
         logic [3:0] mask;
         if (it == 40) begin
            reset = 1'b1;
            repeat (2) @(negedge clk);
            reset = 1'b0;
         end
         if (m_state != 1) cnt_zero = ($urandom_range(0, 3) == 0);
         r = $urandom_range(0, 9);
         if (r < 8) mask = 4'(1 << $urandom_range(0, 3));
         else mask = 4'($urandom_range(1, 15));
         bnc  = 1'($urandom_range(0, 1));
         hold = $urandom_range(1, 10);
         gap  = $urandom_range(0, 12);
         btn = mask;
         if (bnc) begin
            @(negedge clk);
            btn = '0;
            @(negedge clk);
            btn = mask;
         end
         repeat (hold) @(negedge clk);
         btn = '0;
         repeat (gap) @(negedge clk);
      end
      repeat (20) @(negedge clk);

      chk_en = 1'b0;
      #1;
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
